// File: rtl/rtsnoc_pkg.sv
// Shared RTSNoC header field widths, bus-size derivations and header field offsets,
// used by the router, the echo FSM and the rx FIFO.
package rtsnoc_pkg;

    localparam int NOC_LOCAL_ADR_SIZE = 3;

    function automatic int soc_xy_size(input int size_x, input int size_y);
        return size_x + size_y;
    endfunction

    function automatic int noc_header_size(input int size_x, input int size_y);
        return 2 * soc_xy_size(size_x, size_y) + 2 * NOC_LOCAL_ADR_SIZE;
    endfunction

    function automatic int noc_bus_size(input int data_w, input int size_x, input int size_y);
        return data_w + noc_header_size(size_x, size_y);
    endfunction

    // Header sits above the payload: {orig_x, orig_y, dst_x, dst_y, orig_h, dst_h, data}
    function automatic int noc_dst_h_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int noc_orig_h_lsb(input int data_w);
        return data_w + NOC_LOCAL_ADR_SIZE;
    endfunction

    function automatic int noc_dst_y_lsb(input int data_w);
        return data_w + 2 * NOC_LOCAL_ADR_SIZE;
    endfunction

    function automatic int noc_dst_x_lsb(input int data_w, input int size_y);
        return noc_dst_y_lsb(data_w) + size_y;
    endfunction

    function automatic int noc_orig_y_lsb(input int data_w, input int size_x, input int size_y);
        return noc_dst_x_lsb(data_w, size_y) + size_x;
    endfunction

    function automatic int noc_orig_x_lsb(input int data_w, input int size_x, input int size_y);
        return noc_orig_y_lsb(data_w, size_x, size_y) + size_y;
    endfunction

endpackage

// File: rtl/rtsnoc_rx_fifo_stats.sv
// Accepted-flit counter and occupancy high-water mark for the rx FIFO.
// Only instantiated when RTSNOC_RX_FIFO_STATS_EN is defined.
module rtsnoc_rx_fifo_stats
    import rtsnoc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DEPTH_LOG2:0]   level_next_i,
    output logic [15:0]           rx_count_o,
    output logic [DEPTH_LOG2:0]   hwm_o
);

    logic [15:0]         rx_count_q, rx_count_d;
    logic [DEPTH_LOG2:0] hwm_q, hwm_d;

    // Tracking the next level keeps hwm_o aligned with level_o; level never exceeds depth.
    always_comb begin
        rx_count_d = push_i ? rx_count_q + 16'd1 : rx_count_q;
        hwm_d      = (level_next_i > hwm_q) ? level_next_i : hwm_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_count_q <= '0;
            hwm_q      <= '0;
        end else begin
            rx_count_q <= rx_count_d;
            hwm_q      <= hwm_d;
        end
    end

    assign rx_count_o = rx_count_q;
    assign hwm_o      = hwm_q;

endmodule

// File: rtl/rtsnoc_rx_fifo.sv
// First-word fall-through flit buffer between an RTSNoC router local port and its consumer.
// Optional statistics outputs are enabled by defining RTSNOC_RX_FIFO_STATS_EN.
module rtsnoc_rx_fifo
    import rtsnoc_pkg::*;
#(
    parameter  int SOC_SIZE_X     = 1,
    parameter  int SOC_SIZE_Y     = 1,
    parameter  int NOC_DATA_WIDTH = 16,
    parameter  int DEPTH_LOG2     = 2,
    localparam int NOC_BUS_SIZE   = noc_bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NOC_BUS_SIZE-1:0] rt_dout_i,
    input  logic                    rt_nd_i,
    output logic                    rt_rd_o,
    output logic [NOC_BUS_SIZE-1:0] dout_o,
    output logic                    nd_o,
    input  logic                    rd_i,
    output logic [DEPTH_LOG2:0]     level_o
`ifdef RTSNOC_RX_FIFO_STATS_EN
    ,
    output logic [15:0]             rx_count_o,
    output logic [DEPTH_LOG2:0]     hwm_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [NOC_BUS_SIZE-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]     rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_d;
    logic                    full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    // Gating with rst_i keeps the router from retiring a flit that reset would discard.
    assign push = rt_nd_i & ~full & rst_i;
    assign pop  = rd_i & ~empty;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rt_dout_i;
            end
        end
    end

    assign rt_rd_o = push;
    assign nd_o    = ~empty;
    assign dout_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;

`ifdef RTSNOC_RX_FIFO_STATS_EN
    rtsnoc_rx_fifo_stats #(
        .DEPTH_LOG2   (DEPTH_LOG2)
    ) u_stats (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .level_next_i (level_d),
        .rx_count_o   (rx_count_o),
        .hwm_o        (hwm_o)
    );
`endif

endmodule
